// File: rtl/latch_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | latch_write_arbiter: round-robin arbiter sequencing setup/open/hold      |
// | writes into a shared level-sensitive latch bank.           Revision 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module latch_write_arbiter #(
  parameter int WIDTH       = 8,
  parameter int OPEN_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack0,
  output logic             ack1,
  output logic             le,
  output logic [WIDTH-1:0] ld,
  output logic             busy,
  output logic             gnt_id
);

  // Terminal counts; a zero parameter degrades to a single cycle.
  localparam logic [3:0] OPEN_LAST = (OPEN_CYCLES > 1) ? 4'(OPEN_CYCLES - 1) : 4'd0;
  localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES > 1) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       winner;
  logic       grant;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    winner    = (req0 && req1) ? ~gnt_id : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = OPEN;
        cnt_nxt   = 4'd0;
      end
      OPEN: begin
        if (cnt == OPEN_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      le     <= 1'b0;
      ld     <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      busy   <= 1'b0;
      gnt_id <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      le    <= (state_nxt == OPEN);
      busy  <= (state_nxt != IDLE);
      ack0  <= (state_nxt == DONE) && !gnt_id;
      ack1  <= (state_nxt == DONE) &&  gnt_id;
      if (grant) begin
        gnt_id <= winner;
        ld     <= winner ? d1 : d0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_latch_write_arbiter: directed table-driven bench for the arbiter.     |
// |                                                            Revision 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_latch_write_arbiter;

  logic       cp;
  logic       rst_n;
  logic       req0;
  logic [7:0] d0;
  logic       req1;
  logic [7:0] d1;

  logic       ack0, ack1, le, busy, gnt_id;
  logic [7:0] ld;
  logic       ack0_b, ack1_b, le_b, busy_b, gnt_id_b;
  logic [7:0] ld_b;
  logic       ack0_c, ack1_c, le_c, busy_c, gnt_id_c;
  logic [7:0] ld_c;

  int checks   = 0;
  int failures = 0;

  latch_write_arbiter #(.WIDTH(8), .OPEN_CYCLES(2), .HOLD_CYCLES(1)) dut (
    .cp(cp), .rst_n(rst_n), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(ack0), .ack1(ack1), .le(le), .ld(ld), .busy(busy), .gnt_id(gnt_id)
  );

  latch_write_arbiter #(.WIDTH(8), .OPEN_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
    .cp(cp), .rst_n(rst_n), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(ack0_b), .ack1(ack1_b), .le(le_b), .ld(ld_b), .busy(busy_b), .gnt_id(gnt_id_b)
  );

  latch_write_arbiter #(.WIDTH(8), .OPEN_CYCLES(0), .HOLD_CYCLES(0)) dut_c (
    .cp(cp), .rst_n(rst_n), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
    .ack0(ack0_c), .ack1(ack1_c), .le(le_c), .ld(ld_c), .busy(busy_c), .gnt_id(gnt_id_c)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  typedef struct {
    logic       rst;
    logic       r0;
    logic [7:0] d0;
    logic       r1;
    logic [7:0] d1;
    logic       le;
    logic [7:0] ld;
    logic       a0;
    logic       a1;
    logic       busy;
    logic       gnt;
  } vec_t;

  vec_t tab[$];

  task automatic add(input logic rst, input logic r0, input logic [7:0] v0,
                     input logic r1, input logic [7:0] v1, input logic e_le,
                     input logic [7:0] e_ld, input logic e_a0, input logic e_a1,
                     input logic e_busy, input logic e_gnt);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.d0 = v0; v.r1 = r1; v.d1 = v1;
    v.le = e_le; v.ld = e_ld; v.a0 = e_a0; v.a1 = e_a1; v.busy = e_busy; v.gnt = e_gnt;
    tab.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] prev_ld;
    int         n_a0, n_a1, waited;
    int         le_n [3];
    int         ack_e[3];
    int         a1_n [3];

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    step();
    step();
    check("reset_state", {19'd0, le, ld, ack0, ack1, busy, gnt_id}, {19'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;

    // Single write of A5 by requester 0.
    add(1, 1, 8'hA5, 0, 8'h00, 0, 8'hA5, 0, 0, 1, 0);
    add(0, 1, 8'hA5, 0, 8'h00, 1, 8'hA5, 0, 0, 1, 0);
    add(0, 1, 8'hA5, 0, 8'h00, 1, 8'hA5, 0, 0, 1, 0);
    add(0, 1, 8'hA5, 0, 8'h00, 0, 8'hA5, 0, 0, 1, 0);
    add(0, 1, 8'hA5, 0, 8'h00, 0, 8'hA5, 1, 0, 1, 0);
    add(0, 0, 8'hA5, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0);
    add(0, 0, 8'hA5, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 0);
    // Contention from reset, both held: grants 0,1,0.
    add(1, 1, 8'h11, 1, 8'h22, 0, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h11, 1, 8'h22, 1, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h11, 1, 8'h22, 1, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h11, 0, 0, 1, 0);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h11, 1, 0, 1, 0);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h11, 0, 0, 0, 0);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h22, 0, 0, 1, 1);
    add(0, 1, 8'h11, 1, 8'h22, 1, 8'h22, 0, 0, 1, 1);
    add(0, 1, 8'h11, 1, 8'h22, 1, 8'h22, 0, 0, 1, 1);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h22, 0, 0, 1, 1);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h22, 0, 1, 1, 1);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h22, 0, 0, 0, 1);
    add(0, 1, 8'h11, 1, 8'h22, 0, 8'h11, 0, 0, 1, 0);

    prev_ld = ld;
    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) begin
        apply_reset();
        prev_ld = ld;
      end
      req0 = tab[i].r0; d0 = tab[i].d0; req1 = tab[i].r1; d1 = tab[i].d1;
      step();
      check($sformatf("vec%0d", i),
            {19'd0, le, ld, ack0, ack1, busy, gnt_id},
            {19'd0, tab[i].le, tab[i].ld, tab[i].a0, tab[i].a1, tab[i].busy, tab[i].gnt});
      if (ld !== prev_ld) check($sformatf("le_at_ld_change%0d", i), {31'd0, le}, 32'd0);
      prev_ld = ld;
    end

    // Data change after grant must not reach ld.
    apply_reset();
    n_a0 = 0; n_a1 = 0;
    req1 = 1'b1; d1 = 8'h3C;
    step();
    n_a0 += int'(ack0); n_a1 += int'(ack1);
    d1 = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("hold_data_c%0d", c), {24'd0, ld}, {24'd0, 8'h3C});
      n_a0 += int'(ack0); n_a1 += int'(ack1);
    end
    req1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_a0 += int'(ack0); n_a1 += int'(ack1);
    end
    check("data_change_ld_end", {24'd0, ld}, {24'd0, 8'h3C});
    check("data_change_ack1_count", n_a1, 1);
    check("data_change_ack0_count", n_a0, 0);

    // Withdrawn single-cycle request still completes once.
    n_a0 = 0;
    req0 = 1'b1; d0 = 8'h5A;
    step();
    req0 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_a0 += int'(ack0);
    end
    check("withdrawn_ack0_count", n_a0, 1);
    check("withdrawn_idle", {23'd0, busy, ld}, {23'd0, 1'b0, 8'h5A});

    // Asynchronous reset while the enable is open.
    req0 = 1'b1; d0 = 8'h77;
    waited = 0;
    while (!le && waited < 10) begin
      step();
      waited++;
    end
    check("wait_for_le", {31'd0, le}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, le, busy, ack0, ack1}, 32'd0);
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h99; d1 = 8'h66;
    #2;
    rst_n = 1'b1;
    step();
    check("post_reset_grant", {23'd0, gnt_id, ld}, {23'd0, 1'b0, 8'h99});
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Parameter variants: (2,1), (3,2) and (0,0) treated as (1,1).
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      le_n[k] = 0; ack_e[k] = 0; a1_n[k] = 0;
    end
    req0 = 1'b1; d0 = 8'hC3;
    for (int e = 1; e <= 12; e++) begin
      step();
      req0 = 1'b0;
      le_n[0] += int'(le); le_n[1] += int'(le_b); le_n[2] += int'(le_c);
      a1_n[0] += int'(ack1); a1_n[1] += int'(ack1_b); a1_n[2] += int'(ack1_c);
      if (ack0   && ack_e[0] == 0) ack_e[0] = e;
      if (ack0_b && ack_e[1] == 0) ack_e[1] = e;
      if (ack0_c && ack_e[2] == 0) ack_e[2] = e;
    end
    check("p21_le_cycles", le_n[0], 2);
    check("p21_ack_edge", ack_e[0], 5);
    check("p32_le_cycles", le_n[1], 3);
    check("p32_ack_edge", ack_e[1], 7);
    check("p00_le_cycles", le_n[2], 1);
    check("p00_ack_edge", ack_e[2], 4);
    check("param_ack1_none", a1_n[0] + a1_n[1] + a1_n[2], 0);
    check("p32_final", {22'd0, busy_b, gnt_id_b, ld_b}, {22'd0, 1'b0, 1'b0, 8'hC3});
    check("p00_final", {22'd0, busy_c, gnt_id_c, ld_c}, {22'd0, 1'b0, 1'b0, 8'hC3});
    check("p_ack0_low", {29'd0, ack0, ack0_b, ack0_c}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
